rr_sel_arbiter: RTL and testbench
=================================

Name: rr_sel_arbiter

Overview:
Round-robin 4-channel arbiter that generates the select code for the downstream 4:1 data mux (sel[1:0] -> mux, d[3:0] from the four channels).
- Grants one requester at a time, holds the grant for a bounded number of cycles, then rotates priority so no channel starves.
- Registered outputs, so the mux select is glitch-free and stable for the whole grant.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one grant may be held before forced rotation; legal range 1..15.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  per-channel request, level; bit i = channel i.
done  input  1  current grantee finished; sampled only while gnt_valid=1.
sel  output  2  binary index of granted channel; drives 4:1 mux select.
gnt  output  4  one-hot grant; all zero when no grant.
gnt_valid  output  1  high while a grant is active.
hold_cnt  output  4  cycles elapsed in current grant, 0-based.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert handled externally): sel=2'b00, gnt=4'b0000, gnt_valid=0, hold_cnt=0, internal priority pointer ptr=0, state IDLE.
- Reset mid-grant: all of the above immediately, regardless of state. No grant resumes after reset until a new request is seen.
- All outputs are registered. No combinational path from req or done to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at a rising edge, choose the first asserted bit scanning ptr, ptr+1, ... mod 4.
  - Next cycle: state=GRANT, sel=winner, gnt=onehot(winner), gnt_valid=1, hold_cnt=0. Latency is 1 cycle from req to gnt.
  - If req==0, stay IDLE. sel holds its last value (not cleared); gnt=0; gnt_valid=0.
- GRANT:
  - Each cycle without release, hold_cnt increments by 1.
  - Release condition is any of: done=1; req[sel]=0; hold_cnt==HOLD_MAX-1.
  - Simultaneous release conditions count as one release.
- On release:
  - ptr <= sel+1 mod 4 (2-bit wrap, 3 -> 0).
  - Re-arbitrate in the same edge against current req with the new ptr.
  - If any req is set, the next cycle shows the new grant with hold_cnt=0 and no idle bubble; gnt_valid stays 1.
  - If req==0, go to IDLE: gnt=0, gnt_valid=0, hold_cnt=0, sel holds.
  - If only the releasing channel still requests, it is regranted after wrap, with hold_cnt restarting at 0.
- HOLD_MAX=1: every grant lasts exactly one cycle; with all requests active, sel steps 0,1,2,3,0 each cycle.
- hold_cnt never exceeds HOLD_MAX-1. It is 4 bits wide, with no wrap in legal use.
- done while gnt_valid=0 is ignored.
- Invariant: gnt == (gnt_valid ? onehot(sel) : 0) every cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-grant (sel=2, gnt_valid=1) -> same cycle sel=0, gnt=0, gnt_valid=0, hold_cnt=0. After release with req=4'b0100 -> grant ch2 one cycle later.
- Single requester, latency: req=4'b0010 from idle, done held 0, HOLD_MAX=4 -> next cycle sel=1, gnt=4'b0010, gnt_valid=1. hold_cnt runs 0,1,2,3, then ch1 is regranted with hold_cnt=0 and no bubble.
- Round robin: req=4'b1111 held, done=1 every grant cycle -> sel sequence 0,1,2,3,0,1; each grant lasts 1 cycle; gnt_valid constantly 1.
- Forced rotation: HOLD_MAX=3, req=4'b1001, done=0 -> ch0 held 3 cycles (hold_cnt 0,1,2), then ch3 for 3 cycles, then ch0.
- Request drop and idle: grant ch2 with req=4'b0100, then req->0 -> next cycle gnt=0, gnt_valid=0, sel stays 2. Next req=4'b0101 -> grant ch0 (ptr=3 wraps to 0).
- Simultaneous release: done=1 and hold_cnt==HOLD_MAX-1 in the same cycle with req=4'b0011 on ch0 -> exactly one rotation to ch1, ptr=1, no skipped channel.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin 4-channel arbiter producing a registered, glitch-free select for a
// downstream 4:1 data mux. Grants are bounded to HOLD_MAX cycles before rotation.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant active; arbitrate from ptr when any req is seen
// GRANT | channel sel owns the mux; release on done, req drop or hold limit
module rr_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [3:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] sel_n;
    logic [3:0] gnt_n;
    logic       valid_n;
    logic [3:0] hold_n;

    logic [1:0] base;
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;
    logic [1:0] win;
    logic       win_ok;
    logic       release_c;

    // Scan base is ptr from IDLE, or the post-release pointer when rotating.
    assign base    = (state == IDLE) ? ptr : sel + 2'd1;
    assign req_dbl = {req, req} >> base;
    assign req_rot = req_dbl[3:0];

    always_comb begin
        offset = 2'd0;
        win_ok = 1'b1;
        casez (req_rot)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: win_ok = 1'b0;
        endcase
    end

    assign win       = base + offset;
    assign release_c = done | ~req[sel] | (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        valid_n = gnt_valid;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                hold_n  = 4'd0;
                if (win_ok) begin
                    state_n = GRANT;
                    sel_n   = win;
                    valid_n = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_n  = sel + 2'd1;
                    hold_n = 4'd0;
                    if (win_ok) begin
                        sel_n = win;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end else begin
                    hold_n = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                hold_n  = 4'd0;
            end
        endcase
        gnt_n = valid_n ? (4'b0001 << sel_n) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            gnt       <= gnt_n;
            gnt_valid <= valid_n;
            hold_cnt  <= hold_n;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: three instances (HOLD_MAX 4, 3, 1) share stimulus and are
// compared every cycle against a per-instance round-robin reference model.
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [1:0] sel_w  [3];
    logic [3:0] gnt_w  [3];
    logic       vld_w  [3];
    logic [3:0] hold_w [3];

    int hm [3] = '{4, 3, 1};

    int m_valid [3];
    int m_sel   [3];
    int m_cnt   [3];
    int m_ptr   [3];

    int checks;
    int failures;

    rr_sel_arbiter #(.HOLD_MAX(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_w[0]), .gnt(gnt_w[0]), .gnt_valid(vld_w[0]), .hold_cnt(hold_w[0]));
    rr_sel_arbiter #(.HOLD_MAX(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_w[1]), .gnt(gnt_w[1]), .gnt_valid(vld_w[1]), .hold_cnt(hold_w[1]));
    rr_sel_arbiter #(.HOLD_MAX(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_w[2]), .gnt(gnt_w[2]), .gnt_valid(vld_w[2]), .hold_cnt(hold_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0; m_sel[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic model_step();
        int w;
        for (int i = 0; i < 3; i++) begin
            if (m_valid[i] == 0) begin
                w = pick(req, m_ptr[i]);
                m_cnt[i] = 0;
                if (w >= 0) begin
                    m_valid[i] = 1;
                    m_sel[i]   = w;
                end
            end else if (done || !req[m_sel[i]] || m_cnt[i] == hm[i] - 1) begin
                m_ptr[i] = (m_sel[i] + 1) % 4;
                m_cnt[i] = 0;
                w = pick(req, m_ptr[i]);
                if (w >= 0) m_sel[i] = w;
                else m_valid[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, ".sel"}, i, int'(sel_w[i]), m_sel[i]);
            chk({tag, ".gnt"}, i, int'(gnt_w[i]), m_valid[i] != 0 ? (1 << m_sel[i]) : 0);
            chk({tag, ".valid"}, i, int'(vld_w[i]), m_valid[i]);
            chk({tag, ".hold"}, i, int'(hold_w[i]), m_cnt[i]);
        end
    endtask

    // Drive on the falling edge, let the model follow the rising edge, sample 1 time unit later.
    task automatic cycle(input logic [3:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        done     = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle(4'b0010, 1'b0, "latency");
        chk("latency.sel", 0, int'(sel_w[0]), 1);
        chk("latency.gnt", 0, int'(gnt_w[0]), 2);
        for (int c = 0; c < 5; c++) cycle(4'b0010, 1'b0, "single_hold");
        chk("single_regrant.hold", 0, int'(hold_w[0]), 1);

        for (int c = 0; c < 7; c++) cycle(4'b1111, 1'b1, "round_robin");
        for (int c = 0; c < 12; c++) cycle(4'b1001, 1'b0, "forced_rot");

        cycle(4'b0100, 1'b0, "drop_a");
        cycle(4'b0100, 1'b0, "drop_b");
        cycle(4'b0000, 1'b0, "drop_idle");
        chk("drop_idle.valid", 0, int'(vld_w[0]), 0);
        chk("drop_idle.sel", 0, int'(sel_w[0]), 2);
        cycle(4'b0101, 1'b0, "wrap_grant");
        chk("wrap_grant.sel", 0, int'(sel_w[0]), 0);

        for (int c = 0; c < 8; c++) cycle(4'b0011, (c == 3 || c == 7), "simul_rel");

        for (int c = 0; c < 3; c++) cycle(4'b0000, 1'b1, "done_idle");

        cycle(4'b0100, 1'b0, "pre_rst_a");
        cycle(4'b0100, 1'b0, "pre_rst_b");
        chk("pre_rst.sel", 0, int'(sel_w[0]), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        chk("mid_reset.valid", 0, int'(vld_w[0]), 0);
        @(negedge clk);
        cycle(4'b0100, 1'b0, "held_reset");
        rst_n = 1'b1;
        cycle(4'b0100, 1'b0, "post_reset");
        chk("post_reset.sel", 0, int'(sel_w[0]), 2);
        chk("post_reset.gnt", 0, int'(gnt_w[0]), 4);

        for (int c = 0; c < 400; c++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
